// File: rtl/button_event_ctrl.sv
// button_event_ctrl
//   Debounces the bomb panel's eight push buttons, queues press/release events
//   in a small FIFO and exposes status / pop / control registers at
//   0xF330..0xF332. Optional big-button long-press timing is compiled in when
//   the macro BTN_EVENT_HOLD_EN is defined.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   btn_raw  raw asynchronous buttons, [7] morse_left .. [0] bigButton
//   en/we    bus access strobe / write qualifier
//   addr     bus address
//   data     bus write data
//   q        registered read data
//   irq      high while the event FIFO is non-empty
module button_event_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  btn_raw,
  input  logic        en,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  output logic [15:0] q,
  output logic        irq
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    sync1, sync2, deb, pending, flip, served;
  logic [DW-1:0] db_cnt [8];

  logic          push_any;
  logic [2:0]    push_idx;
  logic [15:0]   event_word;
  logic          held_long, long_bit;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, ovf;
  logic          rd_pop, pop, ctrl_wr, flush, do_push, drop;
  logic [15:0]   status;
  logic          unused_bits;

  // A flip happens on the cycle the counter already holds DEBOUNCE_CYCLES-1
  // and the synced level still differs from the debounced level.
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < 8; i++)
      flip[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int unsigned i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 8; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (flip[i]) begin
          db_cnt[i] <= '0;
          deb[i]    <= ~deb[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_EVENT_HOLD_EN
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold_cnt;
  logic          long_flag;

  // The long verdict is latched at the release flip so that a release event
  // delayed by higher-priority pushes still reports the completed hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      long_flag <= 1'b0;
    end else begin
      if (!deb[0])
        hold_cnt <= '0;
      else if (hold_cnt != HW'(HOLD_CYCLES))
        hold_cnt <= hold_cnt + 1'b1;
      if (flip[0] && deb[0])
        long_flag <= (hold_cnt == HW'(HOLD_CYCLES));
    end
  end

  assign held_long = deb[0] && (hold_cnt == HW'(HOLD_CYCLES));
  assign long_bit  = long_flag;
  assign unused_bits = ^data[15:2];
`else
  assign held_long = 1'b0;
  assign long_bit  = 1'b0;
  assign unused_bits = ^{data[15:2], HOLD_CYCLES[0]};
`endif

  // Lowest pending index wins; kind is the current debounced level since a
  // flag is always served long before the same button can flip again.
  always_comb begin
    push_any = 1'b0;
    push_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pending[i] && !push_any) begin
        push_any = 1'b1;
        push_idx = 3'(i);
      end
    end
    served     = push_any ? (8'd1 << push_idx) : '0;
    event_word = {1'b1, deb[push_idx],
                  long_bit && (push_idx == 3'd0) && !deb[0],
                  10'd0, push_idx};
  end

  assign rd_pop  = en && !we && (addr == 16'hF331);
  assign ctrl_wr = en && we && (addr == 16'hF332);
  assign flush   = ctrl_wr && data[0];
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = rd_pop && !empty;
  assign do_push = push_any && !flush && (!full || pop);
  assign drop    = push_any && !flush && full && !pop;
  assign irq     = !empty;
  assign status  = {deb, ovf, held_long, 1'b0, 5'(count)};

  always_ff @(posedge clk) begin
    if (reset)
      pending <= '0;
    else if (flush)
      pending <= '0;
    else
      pending <= (pending & ~served) | flip;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= event_word;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else begin
      if (ctrl_wr && data[1]) ovf <= 1'b0;
      if (drop)               ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      if (we)
        q <= '0;
      else if (addr == 16'hF330)
        q <= status;
      else if (addr == 16'hF331)
        q <= empty ? 16'h0000 : mem[rd_ptr];
      else
        q <= '0;
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl
//   Directed bench for button_event_ctrl with DEBOUNCE_CYCLES=16,
//   HOLD_CYCLES=100, FIFO_DEPTH=4. Honours BTN_EVENT_HOLD_EN for the
//   long-press expectations.
module tb_button_event_ctrl;

  localparam logic [15:0] A_STAT = 16'hF330;
  localparam logic [15:0] A_POP  = 16'hF331;
  localparam logic [15:0] A_CTRL = 16'hF332;

`ifdef BTN_EVENT_HOLD_EN
  localparam logic [15:0] EXP_HOLD_STAT = 16'h0141;
  localparam logic [15:0] EXP_LONG_REL  = 16'hA000;
`else
  localparam logic [15:0] EXP_HOLD_STAT = 16'h0101;
  localparam logic [15:0] EXP_LONG_REL  = 16'h8000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  btn_raw;
  logic        en, we;
  logic [15:0] addr, data;
  logic [15:0] q;
  logic        irq;
  logic [15:0] r;

  int n_tests = 0;
  int n_fail  = 0;

  button_event_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES(100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .en(en), .we(we), .addr(addr), .data(data),
    .q(q), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    en = 1'b1; we = 1'b0; addr = a;
    tick(1);
    en = 1'b0;
    v = q;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    en = 1'b1; we = 1'b1; addr = a; data = d;
    tick(1);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; btn_raw = '0; en = 1'b0; we = 1'b0; addr = '0; data = '0;
    tick(3);
    reset = 1'b0;
    check("reset_q", q, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    rd(A_STAT, r); check("reset_status", r, 16'h0000);

    // glitches on bit 5, then a stable step
    for (int i = 0; i < 10; i++) begin
      btn_raw = 8'h20; tick(1);
      btn_raw = 8'h00; tick(1);
    end
    btn_raw = 8'h20;
    tick(18);
    check("glitch_irq_e18", {15'd0, irq}, 16'h0000);
    tick(1);
    check("glitch_irq_e19", {15'd0, irq}, 16'h0001);
    rd(A_STAT, r); check("glitch_status", r, 16'h2001);
    rd(A_POP, r);  check("glitch_pop", r, 16'hC005);
    rd(A_POP, r);  check("glitch_pop_empty", r, 16'h0000);
    check("glitch_irq_after", {15'd0, irq}, 16'h0000);
    btn_raw = 8'h00;
    tick(25);
    rd(A_POP, r);  check("glitch_release", r, 16'h8005);

    // long hold of the big button
    btn_raw = 8'h01;
    tick(99);
    rd(A_STAT, r); check("hold_stat_early", r, 16'h0101);
    tick(19);
    rd(A_STAT, r); check("hold_stat_120", r, EXP_HOLD_STAT);
    tick(29);
    btn_raw = 8'h00;
    tick(30);
    rd(A_POP, r); check("hold_press", r, 16'hC000);
    rd(A_POP, r); check("hold_release", r, EXP_LONG_REL);
    rd(A_POP, r); check("hold_empty", r, 16'h0000);

    // short press of the big button never marks long
    btn_raw = 8'h01;
    tick(40);
    btn_raw = 8'h00;
    tick(30);
    rd(A_POP, r); check("short_press", r, 16'hC000);
    rd(A_POP, r); check("short_release", r, 16'h8000);

    // simultaneous steps: pushes on consecutive cycles, lowest index first
    btn_raw = 8'h8A;
    tick(19);
    rd(A_STAT, r); check("multi_cnt1", r, 16'h8A01);
    rd(A_STAT, r); check("multi_cnt2", r, 16'h8A02);
    rd(A_STAT, r); check("multi_cnt3", r, 16'h8A03);
    rd(A_POP, r);  check("multi_pop1", r, 16'hC001);
    rd(A_POP, r);  check("multi_pop3", r, 16'hC003);
    rd(A_POP, r);  check("multi_pop7", r, 16'hC007);
    btn_raw = 8'h00;
    tick(25);
    wr(A_CTRL, 16'h0001);
    rd(A_STAT, r); check("multi_flushed", r, 16'h0000);

    // overflow: five events into a four-deep FIFO
    btn_raw = 8'h5E;
    tick(30);
    rd(A_STAT, r); check("ovf_status", r, 16'h5E84);
    check("ovf_irq", {15'd0, irq}, 16'h0001);
    wr(A_CTRL, 16'h0002);
    rd(A_STAT, r); check("ovf_cleared", r, 16'h5E04);
    rd(A_POP, r);  check("ovf_keep1", r, 16'hC001);
    rd(A_POP, r);  check("ovf_keep2", r, 16'hC002);
    rd(A_POP, r);  check("ovf_keep3", r, 16'hC003);
    rd(A_POP, r);  check("ovf_keep4", r, 16'hC004);
    rd(A_POP, r);  check("ovf_empty", r, 16'h0000);
    btn_raw = 8'h00;
    tick(30);
    rd(A_STAT, r); check("ovf_again", r, 16'h0084);
    wr(A_CTRL, 16'h0001);
    rd(A_STAT, r); check("flush_keeps_ovf", r, 16'h0080);
    check("flush_irq", {15'd0, irq}, 16'h0000);
    wr(A_CTRL, 16'h0002);
    rd(A_STAT, r); check("ovf_clear2", r, 16'h0000);

    // pop from a full FIFO on the cycle a new event is pushed
    btn_raw = 8'h1E;
    tick(10);
    btn_raw = 8'h5E;
    tick(18);
    rd(A_POP, r);  check("fullpop_head", r, 16'hC001);
    rd(A_STAT, r); check("fullpop_status", r, 16'h5E04);
    rd(A_POP, r);  check("fullpop_2", r, 16'hC002);
    rd(A_POP, r);  check("fullpop_3", r, 16'hC003);
    rd(A_POP, r);  check("fullpop_4", r, 16'hC004);
    rd(A_POP, r);  check("fullpop_new_last", r, 16'hC006);
    rd(A_POP, r);  check("fullpop_empty", r, 16'h0000);
    btn_raw = 8'h00;
    tick(30);
    wr(A_CTRL, 16'h0003);
    rd(A_STAT, r); check("fullpop_cleanup", r, 16'h0000);

    // reset with queued events and button 2 held
    btn_raw = 8'h07;
    tick(25);
    rd(A_STAT, r); check("rst_pre", r, 16'h0703);
    btn_raw = 8'h04;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_q", q, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    rd(A_STAT, r); check("rst_status", r, 16'h0000);
    tick(25);
    rd(A_STAT, r); check("rst_fresh", r, 16'h0401);
    wr(A_POP, 16'h0000);
    check("wr_pop_q", q, 16'h0000);
    rd(A_STAT, r); check("wr_pop_nopop", r, 16'h0401);
    rd(16'h1234, r); check("bad_addr", r, 16'h0000);
    rd(A_STAT, r);
    tick(2);
    check("en0_hold", q, 16'h0401);
    rd(A_POP, r); check("rst_event", r, 16'hC002);
    rd(A_POP, r); check("rst_empty", r, 16'h0000);
    rd(A_STAT, r); check("rst_final", r, 16'h0400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Input controller for the bomb panel's eight push buttons. It synchronizes and debounces each raw button and turns press/release edges into timestamp-free events in a small FIFO. It measures big-button hold duration and exposes status, event-pop and control registers on the bus at 0xF330–0xF332. This replaces the raw button word at 0xF330, so software sees clean, queued events instead of polling bouncy levels.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a level change; legal range ≥ 16.
- HOLD_CYCLES, 50000000: big-button hold time that marks a press "long"; legal range ≥ 2.
- FIFO_DEPTH, 8: event FIFO entries; power of two, 2..16.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  8  raw buttons, active-high, asynchronous. Bit order: [7] morse_left, [6] morse_right, [5] morse_tx, [4] keypad_TL, [3] keypad_TR, [2] keypad_LL, [1] keypad_LR, [0] button_bigButton.
- en  in  1  bus access strobe.
- we  in  1  write when en=1.
- addr  in  16  bus address.
- data  in  16  write data.
- q  out  16  registered read data.
- irq  out  1  high while the FIFO is non-empty.

## Operation
- **Input conditioning.** Each btn_raw bit passes through a 2-flop synchronizer, then a per-button counter.
  - The counter clears whenever the synced value equals the debounced state.
  - Otherwise the counter increments.
  - On the cycle it reaches DEBOUNCE_CYCLES-1, the debounced bit flips and a pending event flag for that button is set (press if now 1, release if now 0).
- **Event push.** At most one event is pushed per cycle.
  - Pending flags are served by fixed priority, lowest index first; a served flag clears.
  - DEBOUNCE_CYCLES ≥ 16 guarantees no pending flag is overwritten before service.
- **Event word format.**
  - [15] valid=1
  - [14] kind: 1 = press, 0 = release
  - [13] long
  - [12:3] = 0
  - [2:0] button index
- **Hold timing.** A hold counter runs while debounced bit 0 is 1 and saturates at HOLD_CYCLES.
  - A bit-0 release event carries long=1 if the counter reached HOLD_CYCLES; otherwise long=0.
  - long is always 0 for every other event.
  - The counter clears on release.
- **Register map.** Reads apply when en=1, we=0; writes when en=1, we=1.
  - 0xF330 read, status: [15:8] debounced state, in btn_raw order; [7] overflow sticky; [6] big button currently held ≥ HOLD_CYCLES; [5] 0; [4:0] FIFO count.
  - 0xF331 read, pop: q = head entry and the FIFO pops; if empty, q = 0x0000 and nothing pops.
  - 0xF332 write, control: data[0]=1 flushes the FIFO and clears all pending flags; data[1]=1 clears overflow.
  - Any other address, or any write to 0xF330/0xF331: q = 0x0000, no side effects. Reads with en=0 hold q.
- **FIFO boundaries.**
  - Push while full with no pop in the same cycle: the event is dropped and overflow sets.
  - Push and pop in the same cycle while full: both occur and there is no overflow.
  - Push and pop in the same cycle while empty: the pop returns 0x0000 and the push is stored.
  - Flush in the same cycle as a push: flush wins and the event is discarded.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values.** q=0, irq=0, FIFO empty, overflow=0, debounced state=0, counters=0, pending=0.
- **Reset with a button held.** A button held through reset produces a press event after debounce.
- **Debounce latency.** A clean step on btn_raw at edge 0 flips the debounced bit at edge DEBOUNCE_CYCLES+2.
  - An uncontended push lands at edge DEBOUNCE_CYCLES+3; count and irq update at that edge.
  - Each contending lower-index event adds one cycle.
- **Read latency.** q is valid 1 cycle after the en strobe. A pop's count decrement is visible to a status read on the next access.
- **Hold latency.** Status bit [6] rises HOLD_CYCLES cycles after the debounced bit 0 rises.
- **Reset mid-operation.** Reset clears everything on the next edge; in-flight events are lost.

## Configuration
- `BTN_EVENT_HOLD_EN` defined: the hold counter, event bit [13] and status bit [6] behave as described above.
- Not defined: no hold counter is built; bit [13] and status bit [6] read 0; HOLD_CYCLES is ignored.

## Test plan
All scenarios use DEBOUNCE_CYCLES=16, HOLD_CYCLES=100, FIFO_DEPTH=4.
- Step btn_raw[5] high and hold, with 10 cycles of 1-cycle glitches first → exactly one event after the last glitch. Status reads 0x2001 after edge 19 of the stable run; pop returns 0xC005, then 0x0000.
- Hold btn_raw[0] for 150 cycles, then release → events 0xC000 and 0xA000 in order (with the hold macro off: 0x8000). Status bit [6]=1 at hold cycle 120.
- Step bits 7, 3 and 1 high in the same cycle → three events pushed on consecutive cycles, in order 0xC001, 0xC003, 0xC007.
- Queue 5 events with no pops → count=4, overflow=1, first four events retained. Write 0x0002 to 0xF332 → overflow=0. Write 0x0001 → count=0, irq=0.
- Pop from a full FIFO on the same cycle a new event pushes → count stays 4, overflow stays 0, and the new event is last.
- Assert reset with 3 queued events and btn_raw[2] held → status 0x0000 on the next read, then a fresh 0xC002 event after debounce.
